morse_key_decoder: RTL and testbench

//  Receive side of the Morse trainer: decodes letters A-H keyed by hand on one push button.

---
 rtl/morse_key_decoder_if.sv | 26 ++
 rtl/morse_key_decoder.sv | 190 +++++++++++++++++++
 tb/tb_morse_key_decoder.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_key_decoder_if.sv
// Morse key decoder bus: raw key in, symbol/letter pulses and held letter out.
interface morse_key_decoder_if;
  logic       key_i;
  logic       dot_o;
  logic       dash_o;
  logic       letter_valid_o;
  logic [2:0] letter_o;
  logic [3:0] code_o;
  logic [2:0] len_o;
  logic       error_o;
  logic       busy_o;

  modport slave (
    input  key_i,
    output dot_o, dash_o, letter_valid_o,
    output letter_o, code_o, len_o,
    output error_o, busy_o
  );

  modport master (
    output key_i,
    input  dot_o, dash_o, letter_valid_o,
    input  letter_o, code_o, len_o,
    input  error_o, busy_o
  );
endinterface

// File: rtl/morse_key_decoder.sv
// Decodes hand-keyed Morse letters A-H from one active-low push button.
// Presses become dots/dashes, a long release closes the letter.
module morse_key_decoder #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int DASH_UNITS = 2,
  parameter int GAP_UNITS  = 3,
  parameter int MAX_SYM    = 4
) (
  input logic CLOCK50_i,
  input logic reset_i,
  morse_key_decoder_if.slave bus
);

  localparam int CW = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          key_s1_q, key_s1_d;
  logic          key_s2_q, key_s2_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    unit_q, unit_d;
  logic [3:0]    buf_q, buf_d;
  logic [2:0]    len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          dot_q, dot_d;
  logic          dash_q, dash_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [2:0]    letter_q, letter_d;
  logic [3:0]    code_q, code_d;
  logic [2:0]    lout_q, lout_d;

  logic       pressed;
  logic       wrap;
  logic       enter;
  logic       sym;
  logic [3:0] dec;

  // {hit, index}; code bit0 is the first symbol, 1 = dash
  function automatic logic [3:0] decode(
    input logic [2:0] l,
    input logic [3:0] c
  );
    case ({l, c})
      7'b001_0000: decode = 4'b1_100;
      7'b010_0010: decode = 4'b1_000;
      7'b011_0001: decode = 4'b1_011;
      7'b011_0011: decode = 4'b1_110;
      7'b100_0001: decode = 4'b1_001;
      7'b100_0101: decode = 4'b1_010;
      7'b100_0100: decode = 4'b1_101;
      7'b100_0000: decode = 4'b1_111;
      default:     decode = 4'b0_000;
    endcase
  endfunction

  assign pressed = ~key_s2_q;
  assign wrap    = (cyc_q == CW'(TICK_DIV - 1));
  assign sym     = (unit_q >= 3'(DASH_UNITS));
  assign dec     = decode(len_q, buf_q);

  always_comb begin
    state_d  = state_q;
    key_s1_d = bus.key_i;
    key_s2_d = key_s1_q;
    cyc_d    = cyc_q;
    unit_d   = unit_q;
    buf_d    = buf_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    dot_d    = 1'b0;
    dash_d   = 1'b0;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    letter_d = letter_q;
    code_d   = code_q;
    lout_d   = lout_q;
    enter    = 1'b0;

    if (state_q != IDLE) begin
      cyc_d = wrap ? '0 : cyc_q + 1'b1;
      if (wrap && unit_q != 3'd7)
        unit_d = unit_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS;
          enter   = 1'b1;
        end
      end
      PRESS: begin
        if (!pressed) begin
          dash_d  = sym;
          dot_d   = ~sym;
          if (len_q < 3'(MAX_SYM)) begin
            buf_d[len_q[1:0]] = sym;
            len_d = len_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          state_d = GAP;
          enter   = 1'b1;
        end
      end
      GAP: begin
        if (pressed) begin
          state_d = PRESS;
          enter   = 1'b1;
        end else if (unit_q == 3'(GAP_UNITS)) begin
          if (dec[3] && !ovf_q) begin
            valid_d  = 1'b1;
            letter_d = dec[2:0];
            code_d   = buf_q;
            lout_d   = len_q;
          end else begin
            err_d = 1'b1;
          end
          buf_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
          enter   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        enter   = 1'b1;
      end
    endcase

    if (enter) begin
      cyc_d  = '0;
      unit_d = '0;
    end
  end

  always_ff @(posedge CLOCK50_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      cyc_q    <= '0;
      unit_q   <= '0;
      buf_q    <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      dot_q    <= 1'b0;
      dash_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      letter_q <= '0;
      code_q   <= '0;
      lout_q   <= '0;
    end else begin
      state_q  <= state_d;
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      cyc_q    <= cyc_d;
      unit_q   <= unit_d;
      buf_q    <= buf_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      dot_q    <= dot_d;
      dash_q   <= dash_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      letter_q <= letter_d;
      code_q   <= code_d;
      lout_q   <= lout_d;
    end
  end

  assign bus.dot_o          = dot_q;
  assign bus.dash_o         = dash_q;
  assign bus.letter_valid_o = valid_q;
  assign bus.letter_o       = letter_q;
  assign bus.code_o         = code_q;
  assign bus.len_o          = lout_q;
  assign bus.error_o        = err_q;
  assign bus.busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder with TICK_DIV=4.
// Pulse counters run on a monitor; each scenario task checks its own results.
module tb_morse_key_decoder;

  logic clk;
  logic rst;

  int n_chk;
  int n_fail;

  int dot_cnt, dash_cnt, valid_cnt, err_cnt, excl_cnt;
  logic [7:0] seq;

  morse_key_decoder_if bus();

  morse_key_decoder #(
    .TICK_DIV  (4),
    .DASH_UNITS(2),
    .GAP_UNITS (3),
    .MAX_SYM   (4)
  ) dut (
    .CLOCK50_i(clk),
    .reset_i  (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.dot_o) begin
      dot_cnt++;
      seq = {seq[6:0], 1'b0};
    end
    if (bus.dash_o) begin
      dash_cnt++;
      seq = {seq[6:0], 1'b1};
    end
    if (bus.letter_valid_o) valid_cnt++;
    if (bus.error_o) err_cnt++;
    if ((int'(bus.dot_o) + int'(bus.dash_o) +
         int'(bus.letter_valid_o) + int'(bus.error_o)) > 1)
      excl_cnt++;
  end

  task automatic clear_counts();
    dot_cnt   = 0;
    dash_cnt  = 0;
    valid_cnt = 0;
    err_cnt   = 0;
    seq       = '0;
  endtask

  task automatic press(input int n);
    @(negedge clk);
    bus.key_i = 1'b0;
    repeat (n) @(negedge clk);
    bus.key_i = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dot();
    press(4);
    idle(3);
  endtask

  task automatic dash();
    press(12);
    idle(3);
  endtask

  task automatic end_gap();
    idle(24);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.key_i = 1'b1;
    idle(3);
    n_chk++;
    if ({bus.dot_o, bus.dash_o, bus.letter_valid_o, bus.error_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_pulses got=%b want=0000",
               {bus.dot_o, bus.dash_o, bus.letter_valid_o, bus.error_o});
    end
    n_chk++;
    if ({bus.letter_o, bus.code_o, bus.len_o} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_letter got=%h want=0",
               {bus.letter_o, bus.code_o, bus.len_o});
    end
    n_chk++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got=%b want=0", bus.busy_o);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_e();
    clear_counts();
    @(negedge clk);
    bus.key_i = 1'b0;
    idle(3);
    n_chk++;
    if (bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL e_busy got=%b want=1", bus.busy_o);
    end
    idle(1);
    bus.key_i = 1'b1;
    end_gap();
    n_chk++;
    if (dot_cnt !== 1 || dash_cnt !== 0) begin
      n_fail++;
      $display("FAIL e_syms got dot=%0d dash=%0d want 1/0", dot_cnt, dash_cnt);
    end
    n_chk++;
    if (valid_cnt !== 1 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL e_valid got v=%0d e=%0d want 1/0", valid_cnt, err_cnt);
    end
    n_chk++;
    if ({bus.letter_o, bus.len_o, bus.code_o} !== {3'd4, 3'd1, 4'b0000}) begin
      n_fail++;
      $display("FAIL e_letter got l=%0d n=%0d c=%b want 4/1/0000",
               bus.letter_o, bus.len_o, bus.code_o);
    end
    n_chk++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL e_idle got=%b want=0", bus.busy_o);
    end
  endtask

  task automatic test_a();
    clear_counts();
    dot();
    dash();
    end_gap();
    n_chk++;
    if (dot_cnt !== 1 || dash_cnt !== 1 || seq[1:0] !== 2'b01) begin
      n_fail++;
      $display("FAIL a_order got dot=%0d dash=%0d seq=%b want 1/1/01",
               dot_cnt, dash_cnt, seq[1:0]);
    end
    n_chk++;
    if ({valid_cnt[3:0], bus.letter_o, bus.len_o, bus.code_o} !==
        {4'd1, 3'd0, 3'd2, 4'b0010}) begin
      n_fail++;
      $display("FAIL a_letter got v=%0d l=%0d n=%0d c=%b want 1/0/2/0010",
               valid_cnt, bus.letter_o, bus.len_o, bus.code_o);
    end
  endtask

  task automatic test_c_then_t();
    clear_counts();
    dash();
    dot();
    dash();
    dot();
    end_gap();
    n_chk++;
    if ({valid_cnt[3:0], bus.letter_o, bus.len_o, bus.code_o} !==
        {4'd1, 3'd2, 3'd4, 4'b0101}) begin
      n_fail++;
      $display("FAIL c_letter got v=%0d l=%0d n=%0d c=%b want 1/2/4/0101",
               valid_cnt, bus.letter_o, bus.len_o, bus.code_o);
    end
    clear_counts();
    dash();
    end_gap();
    n_chk++;
    if (err_cnt !== 1 || valid_cnt !== 0 || dash_cnt !== 1) begin
      n_fail++;
      $display("FAIL t_error got e=%0d v=%0d d=%0d want 1/0/1",
               err_cnt, valid_cnt, dash_cnt);
    end
    n_chk++;
    if ({bus.letter_o, bus.len_o, bus.code_o} !== {3'd2, 3'd4, 4'b0101}) begin
      n_fail++;
      $display("FAIL t_hold got l=%0d n=%0d c=%b want 2/4/0101",
               bus.letter_o, bus.len_o, bus.code_o);
    end
  endtask

  task automatic test_overflow();
    clear_counts();
    for (int i = 0; i < 5; i++) dot();
    end_gap();
    n_chk++;
    if (err_cnt !== 1 || valid_cnt !== 0 || dot_cnt !== 5) begin
      n_fail++;
      $display("FAIL ovf_error got e=%0d v=%0d dots=%0d want 1/0/5",
               err_cnt, valid_cnt, dot_cnt);
    end
    clear_counts();
    for (int i = 0; i < 4; i++) dot();
    end_gap();
    n_chk++;
    if ({valid_cnt[3:0], err_cnt[3:0], bus.letter_o, bus.len_o, bus.code_o} !==
        {4'd1, 4'd0, 3'd7, 3'd4, 4'b0000}) begin
      n_fail++;
      $display("FAIL h_letter got v=%0d e=%0d l=%0d n=%0d c=%b want 1/0/7/4/0000",
               valid_cnt, err_cnt, bus.letter_o, bus.len_o, bus.code_o);
    end
  endtask

  task automatic test_long_hold();
    clear_counts();
    press(200);
    end_gap();
    n_chk++;
    if (dash_cnt !== 1 || dot_cnt !== 0) begin
      n_fail++;
      $display("FAIL hold_dash got dash=%0d dot=%0d want 1/0", dash_cnt, dot_cnt);
    end
    n_chk++;
    if (err_cnt !== 1 || valid_cnt !== 0) begin
      n_fail++;
      $display("FAIL hold_error got e=%0d v=%0d want 1/0", err_cnt, valid_cnt);
    end
  endtask

  task automatic test_reset_mid();
    dot();
    @(negedge clk);
    bus.key_i = 1'b0;
    idle(5);
    rst = 1'b1;
    idle(1);
    bus.key_i = 1'b1;
    idle(2);
    n_chk++;
    if ({bus.busy_o, bus.letter_o, bus.code_o, bus.len_o} !== 11'd0) begin
      n_fail++;
      $display("FAIL mid_reset_out got=%h want=0",
               {bus.busy_o, bus.letter_o, bus.code_o, bus.len_o});
    end
    clear_counts();
    rst = 1'b0;
    idle(30);
    n_chk++;
    if (dot_cnt + dash_cnt + valid_cnt + err_cnt !== 0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet got d=%0d s=%0d v=%0d e=%0d busy=%b want 0",
               dot_cnt, dash_cnt, valid_cnt, err_cnt, bus.busy_o);
    end
    dot();
    end_gap();
    n_chk++;
    if ({valid_cnt[3:0], dot_cnt[3:0], bus.letter_o, bus.len_o} !==
        {4'd1, 4'd1, 3'd4, 3'd1}) begin
      n_fail++;
      $display("FAIL mid_reset_e got v=%0d d=%0d l=%0d n=%0d want 1/1/4/1",
               valid_cnt, dot_cnt, bus.letter_o, bus.len_o);
    end
  endtask

  task automatic test_exclusive();
    n_chk++;
    if (excl_cnt !== 0) begin
      n_fail++;
      $display("FAIL exclusive got=%0d want=0 overlapping pulse cycles", excl_cnt);
    end
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    excl_cnt = 0;
    rst      = 1'b1;
    bus.key_i = 1'b1;
    clear_counts();
    test_reset();
    test_e();
    test_a();
    test_c_then_t();
    test_overflow();
    test_long_hold();
    test_reset_mid();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
